struct_ser_tx: RTL

STRUCT_SER_TX -- requirements
Module: struct_ser_tx

---
 rtl/struct_ser_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/struct_ser_tx.sv
// ---------------------------------------------------------------------------
// struct_ser_tx
//
// Purpose:
//    Serializes a 33-bit packed record into a stream of bytes over a
//    valid/ready interface. Each frame is an optional sync byte followed by
//    {7'b0,a}, b, t, ps.a and ps.b. The final beat is flagged with out_last.
//    Back-to-back frames are accepted with no idle cycle between them.
//
// Parameters:
//    SYNC_EN    1 = prefix every frame with SYNC_BYTE, 0 = no sync byte
//    SYNC_BYTE  value of the sync byte
//
// Ports:
//    clk        single clock, rising edge
//    rst        synchronous active-high reset
//    in_s       packed record [32]=a [31:24]=b [23:16]=t [15:8]=ps.a [7:0]=ps.b
//    in_valid   in_s is valid this cycle
//    in_ready   block accepts in_s this cycle (combinational)
//    out_data   serialized byte (registered)
//    out_valid  out_data holds a valid beat
//    out_ready  downstream accepts the beat this cycle
//    out_last   current beat is the final beat of the frame
//    frame_cnt  count of completed frames, wraps at 16 bits
// ---------------------------------------------------------------------------
module struct_ser_tx #(
   parameter int         SYNC_EN   = 1,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [32:0] in_s,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic [15:0] frame_cnt
);

   localparam int BEATS = (SYNC_EN != 0) ? 6 : 5;
   localparam int IDX_W = $clog2(BEATS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] beat_idx;
   logic [IDX_W-1:0] beat_idx_next;
   logic [32:0]      hold_reg;
   logic [32:0]      hold_next;
   logic [7:0]       data_next;
   logic             valid_next;
   logic             last_next;
   logic [15:0]      cnt_next;
   logic             accept;
   logic             beat_xfer;
   logic             last_xfer;

   // Maps a beat index to its byte. Without a sync byte the index is shifted
   // by one so both frame formats share the same field positions.
   function automatic logic [7:0] beat_byte(input logic [32:0]      frame,
                                            input logic [IDX_W-1:0] idx);
      logic [2:0] pos;
      pos = (SYNC_EN != 0) ? 3'(idx) : 3'(idx) + 3'd1;
      case (pos)
         3'd0:    beat_byte = SYNC_BYTE;
         3'd1:    beat_byte = {7'b0, frame[32]};
         3'd2:    beat_byte = frame[31:24];
         3'd3:    beat_byte = frame[23:16];
         3'd4:    beat_byte = frame[15:8];
         3'd5:    beat_byte = frame[7:0];
         default: beat_byte = 8'h00;
      endcase
   endfunction

   // Handshake decodes. in_ready opens on the last-beat handshake so that the
   // next frame can be loaded on the same edge the current one finishes.
   assign beat_xfer = out_valid && out_ready;
   assign last_xfer = beat_xfer && out_last;
   assign in_ready  = !rst && (state == IDLE || last_xfer);
   assign accept    = in_valid && in_ready;

   // Next-state and next-output logic. Loading a frame presents its first beat
   // immediately so out_valid rises on the accepting edge; frames always have
   // at least five beats, so the first beat is never the last one.
   always_comb begin
      state_next    = state;
      beat_idx_next = beat_idx;
      hold_next     = hold_reg;
      data_next     = out_data;
      valid_next    = out_valid;
      last_next     = out_last;
      cnt_next      = frame_cnt;

      if (last_xfer) begin
         cnt_next = frame_cnt + 16'd1;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               state_next    = SEND;
               hold_next     = in_s;
               beat_idx_next = '0;
               data_next     = beat_byte(in_s, '0);
               valid_next    = 1'b1;
               last_next     = 1'b0;
            end
         end
         SEND: begin
            if (last_xfer) begin
               if (accept) begin
                  hold_next     = in_s;
                  beat_idx_next = '0;
                  data_next     = beat_byte(in_s, '0);
                  valid_next    = 1'b1;
                  last_next     = 1'b0;
               end else begin
                  state_next    = IDLE;
                  beat_idx_next = '0;
                  valid_next    = 1'b0;
                  last_next     = 1'b0;
               end
            end else if (beat_xfer) begin
               beat_idx_next = beat_idx + IDX_W'(1);
               data_next     = beat_byte(hold_reg, beat_idx_next);
               last_next     = (beat_idx_next == LAST_IDX);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers. Reset abandons any frame in flight without
   // counting it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         beat_idx  <= '0;
         hold_reg  <= '0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_cnt <= 16'h0000;
      end else begin
         state     <= state_next;
         beat_idx  <= beat_idx_next;
         hold_reg  <= hold_next;
         out_data  <= data_next;
         out_valid <= valid_next;
         out_last  <= last_next;
         frame_cnt <= cnt_next;
      end
   end

endmodule
